// File: rtl/ahbl_pkg.sv
// rtl/ahbl_pkg.sv - shared AHB-Lite encodings and DMA state type
package ahbl_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DATA    = 4'b0011;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_DONE,
    ST_ERR
  } dma_state_t;

endpackage

// File: rtl/ahbl_dma_if.sv
// rtl/ahbl_dma_if.sv - AHB-Lite bus bundle between the DMA master and a slave
interface ahbl_dma_if;

  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  modport master (
    output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
    output HRDATA, HREADY, HRESP
  );

endinterface

// File: rtl/ahbl_dma.sv
// rtl/ahbl_dma.sv - single-channel word-copy DMA, AHB-Lite master; optional irq via AHBL_DMA_IRQ_EN
module ahbl_dma
  import ahbl_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             err,
`ifdef AHBL_DMA_IRQ_EN
  output logic             irq,
  input  logic             irq_clr,
`endif
  ahbl_dma_if.master       ahb
);

  dma_state_t       state;
  dma_state_t       state_n;
  logic [29:0]      src_q;
  logic [29:0]      dst_q;
  logic [LEN_W-1:0] count_q;
  logic [31:0]      data_q;
  logic             accept;
  logic             rd_ok;
  logic             wr_ok;

  // Addresses are word-granular; the byte-offset bits are deliberately dropped.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{src_addr[1:0], dst_addr[1:0]};

  assign accept = (state == ST_IDLE) && start;
  assign rd_ok  = (state == ST_RD_DATA) && ahb.HREADY && !ahb.HRESP;
  assign wr_ok  = (state == ST_WR_DATA) && ahb.HREADY && !ahb.HRESP;

  // State register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= ST_IDLE;
    else          state <= state_n;
  end

  // Next-state: one read then one write per word; an error response aborts at once
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:    if (start) state_n = (len == '0) ? ST_DONE : ST_RD_ADDR;
      ST_RD_ADDR: if (ahb.HREADY) state_n = ST_RD_DATA;
      ST_RD_DATA: begin
        if (ahb.HRESP)       state_n = ST_ERR;
        else if (ahb.HREADY) state_n = ST_WR_ADDR;
      end
      ST_WR_ADDR: if (ahb.HREADY) state_n = ST_WR_DATA;
      ST_WR_DATA: begin
        if (ahb.HRESP)       state_n = ST_ERR;
        else if (ahb.HREADY) state_n = (count_q == LEN_W'(1)) ? ST_DONE : ST_RD_ADDR;
      end
      ST_DONE:    state_n = ST_IDLE;
      ST_ERR:     state_n = ST_IDLE;
      default:    state_n = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; address and write data come from held registers so they never glitch
  always_comb begin
    ahb.HTRANS    = HTRANS_IDLE;
    ahb.HWRITE    = 1'b0;
    ahb.HADDR     = {src_q, 2'b00};
    ahb.HWDATA    = data_q;
    ahb.HSIZE     = HSIZE_WORD;
    ahb.HBURST    = HBURST_SINGLE;
    ahb.HPROT     = HPROT_DATA;
    ahb.HMASTLOCK = 1'b0;
    busy          = (state != ST_IDLE);
    done          = (state == ST_DONE);
    if ((state == ST_RD_ADDR) || (state == ST_WR_ADDR)) ahb.HTRANS = HTRANS_NONSEQ;
    if ((state == ST_WR_ADDR) || (state == ST_WR_DATA)) begin
      ahb.HWRITE = 1'b1;
      ahb.HADDR  = {dst_q, 2'b00};
    end
  end

  // Datapath: latch the job on start, capture read data, advance pointers after each write
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      src_q   <= '0;
      dst_q   <= '0;
      count_q <= '0;
      data_q  <= '0;
    end else begin
      if (accept) begin
        src_q   <= src_addr[31:2];
        dst_q   <= dst_addr[31:2];
        count_q <= len;
      end
      if (rd_ok) data_q <= ahb.HRDATA;
      if (wr_ok) begin
        src_q   <= src_q + 30'd1;
        dst_q   <= dst_q + 30'd1;
        count_q <= count_q - LEN_W'(1);
      end
    end
  end

  // Sticky error flag: set on entering ERR, cleared only by the next accepted start
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)                                   err <= 1'b0;
    else if (accept)                                err <= 1'b0;
    else if ((state_n == ST_ERR) && (state != ST_ERR)) err <= 1'b1;
  end

`ifdef AHBL_DMA_IRQ_EN
  // Interrupt latches on entry to DONE or ERR; a set on the same edge as irq_clr wins
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)
      irq <= 1'b0;
    else if ((state_n != state) && ((state_n == ST_DONE) || (state_n == ST_ERR)))
      irq <= 1'b1;
    else if (irq_clr)
      irq <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_ahbl_dma.sv
// tb/tb_ahbl_dma.sv - randomized copy jobs against a word-memory slave and address/data reference model
module tb_ahbl_dma;

  localparam int LEN_W = 16;

  logic             HCLK = 1'b0;
  logic             HRESETn = 1'b0;
  logic             start = 1'b0;
  logic [31:0]      src_addr = '0;
  logic [31:0]      dst_addr = '0;
  logic [LEN_W-1:0] len = '0;
  logic             busy;
  logic             done;
  logic             err;

  ahbl_dma_if bus ();

  ahbl_dma #(.LEN_W(LEN_W)) dut (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .start    (start),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .len      (len),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .ahb      (bus)
  );

  always #5 HCLK = ~HCLK;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] rd_log [$];
  logic [31:0] wr_log [$];
  int          wr_stall = 0;
  int          err_rd_idx = -1;
  int          rd_idx = 0;
  int          addr_phases = 0;
  logic [31:0] stall_addr_exp = '0;
  bit          dp_valid = 0;
  bit          dp_write = 0;
  bit          dp_err = 0;
  bit          err_cyc = 0;
  logic [31:0] dp_addr = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'hDEAD_0000 ^ a;
  endfunction

  always @(negedge HCLK) begin
    if (!HRESETn) begin
      dp_valid   = 0;
      err_cyc    = 0;
      bus.HREADY = 1'b1;
      bus.HRESP  = 1'b0;
      bus.HRDATA = '0;
    end else if (dp_valid) begin
      if (dp_err && !err_cyc) begin
        bus.HREADY = 1'b0;
        bus.HRESP  = 1'b1;
        err_cyc    = 1;
      end else if (dp_err) begin
        bus.HREADY = 1'b1;
        bus.HRESP  = 1'b1;
        err_cyc    = 0;
        dp_valid   = 0;
      end else begin
        bus.HREADY = 1'b1;
        bus.HRESP  = 1'b0;
        if (dp_write) begin
          mem[dp_addr] = bus.HWDATA;
          wr_log.push_back(dp_addr);
        end else begin
          bus.HRDATA = mem_rd(dp_addr);
        end
        dp_valid = 0;
      end
    end else begin
      bus.HRESP = 1'b0;
      if (bus.HTRANS == 2'b10) begin
        addr_phases++;
        if (bus.HWRITE && wr_stall > 0) begin
          check("stall_haddr", bus.HADDR, stall_addr_exp);
          check("stall_hwrite", 32'(bus.HWRITE), 32'd1);
          bus.HREADY = 1'b0;
          wr_stall--;
        end else begin
          bus.HREADY = 1'b1;
          dp_valid   = 1;
          dp_addr    = bus.HADDR;
          dp_write   = bus.HWRITE;
          dp_err     = !bus.HWRITE && (rd_idx == err_rd_idx);
          if (!bus.HWRITE) begin
            rd_log.push_back(bus.HADDR);
            rd_idx++;
          end
        end
      end else begin
        bus.HREADY = 1'b1;
      end
    end
  end

  task automatic check_reset_values(input string name);
    check({name, "_htrans"}, 32'(bus.HTRANS), 32'd0);
    check({name, "_haddr"},  bus.HADDR,       32'd0);
    check({name, "_hwrite"}, 32'(bus.HWRITE), 32'd0);
    check({name, "_hwdata"}, bus.HWDATA,      32'd0);
    check({name, "_busy"},   32'(busy),       32'd0);
    check({name, "_done"},   32'(done),       32'd0);
    check({name, "_err"},    32'(err),        32'd0);
  endtask

  task automatic run_copy(input string name, input logic [31:0] s, input logic [31:0] d,
                          input int n, input int stall, input int err_idx,
                          input int busy_start_at, input bit do_reset);
    logic [31:0] data [$];
    logic [31:0] sb;
    logic [31:0] db;
    int cyc;
    int done_cyc;
    int done_cnt;
    int err_seen;
    int idle_cyc;
    sb = s & 32'hFFFF_FFFC;
    db = d & 32'hFFFF_FFFC;
    for (int i = 0; i < n; i++) begin
      mem[sb + 32'(4 * i)] = $urandom;
      data.push_back(mem[sb + 32'(4 * i)]);
      if (mem.exists(db + 32'(4 * i))) mem.delete(db + 32'(4 * i));
    end
    rd_log.delete();
    wr_log.delete();
    rd_idx         = 0;
    err_rd_idx     = err_idx;
    wr_stall       = stall;
    stall_addr_exp = db;
    addr_phases    = 0;
    done_cyc       = -1;
    done_cnt       = 0;
    err_seen       = -1;
    idle_cyc       = -1;

    start    = 1'b1;
    src_addr = s;
    dst_addr = d;
    len      = LEN_W'(n);
    @(negedge HCLK);
    start = 1'b0;
    cyc   = 1;
    check({name, "_err_cleared"}, 32'(err), 32'd0);

    while (cyc < 400) begin
      if (done) begin
        if (done_cyc < 0) done_cyc = cyc;
        done_cnt++;
      end
      if (err && err_seen < 0) begin
        err_seen = cyc;
        check({name, "_htrans_in_err"}, 32'(bus.HTRANS), 32'd0);
      end
      if (!busy) begin
        idle_cyc = cyc;
        break;
      end
      if (cyc == busy_start_at) begin
        start    = 1'b1;
        src_addr = 32'h5555_0000;
        dst_addr = 32'h6666_0000;
        len      = LEN_W'(7);
      end else begin
        start = 1'b0;
      end
      if (do_reset && cyc == 4) begin
        check({name, "_hwdata_wr"}, bus.HWDATA, data[0]);
        HRESETn = 1'b0;
        #1;
        check_reset_values({name, "_async"});
        @(negedge HCLK);
        HRESETn = 1'b1;
        return;
      end
      @(negedge HCLK);
      cyc++;
    end

    check({name, "_terminated"}, 32'(idle_cyc >= 0), 32'd1);
    if (err_idx < 0) begin
      check({name, "_latency"}, 32'(done_cyc), 32'(4 * n + 1 + stall));
      check({name, "_done_width"}, 32'(done_cnt), 32'd1);
      check({name, "_err"}, 32'(err), 32'd0);
      check({name, "_n_reads"}, 32'(rd_log.size()), 32'(n));
      check({name, "_n_writes"}, 32'(wr_log.size()), 32'(n));
      for (int i = 0; i < n; i++) begin
        check($sformatf("%s_rd_addr%0d", name, i), rd_log[i], sb + 32'(4 * i));
        check($sformatf("%s_wr_addr%0d", name, i), wr_log[i], db + 32'(4 * i));
        check($sformatf("%s_word%0d", name, i), mem_rd(db + 32'(4 * i)), data[i]);
      end
    end else begin
      check({name, "_err_sticky"}, 32'(err), 32'd1);
      check({name, "_no_done"}, 32'(done_cnt), 32'd0);
      check({name, "_idle_after_err"}, 32'(idle_cyc), 32'(err_seen + 1));
      check({name, "_n_reads"}, 32'(rd_log.size()), 32'(err_idx + 1));
      check({name, "_n_writes"}, 32'(wr_log.size()), 32'(err_idx));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rs;
    int          rn;
    int          rst;
    HRESETn = 1'b0;
    repeat (3) @(negedge HCLK);
    check_reset_values("reset");
    HRESETn = 1'b1;
    @(negedge HCLK);
    check_reset_values("post_reset");

    run_copy("basic", 32'h0000_0100, 32'h0000_0200, 3, 0, -1, -1, 0);

    run_copy("len0", 32'h0000_0300, 32'h0000_0400, 0, 0, -1, -1, 0);
    check("len0_no_transfer", 32'(addr_phases), 32'd0);

    run_copy("stall", 32'h0000_1000, 32'h0000_2000, 2, 2, -1, -1, 0);

    run_copy("rderr", 32'h0000_3000, 32'h0000_4000, 3, 0, 1, -1, 0);

    run_copy("after_err", 32'h0000_3101, 32'h0000_4102, 2, 0, -1, -1, 0);

    run_copy("busy_start", 32'h0000_5000, 32'h0000_6000, 3, 0, -1, 5, 0);

    run_copy("reset_mid", 32'h0000_7000, 32'h0000_8000, 2, 0, -1, -1, 1);
    check_reset_values("after_mid_reset");

    run_copy("wrap", 32'hFFFF_FFFC, 32'h0000_9000, 2, 0, -1, -1, 0);
    check("wrap_second_rd", rd_log[1], 32'h0000_0000);

    for (int t = 0; t < 6; t++) begin
      rs  = $urandom;
      rn  = $urandom_range(1, 6);
      rst = $urandom_range(0, 2);
      run_copy($sformatf("rand%0d", t), rs, rs + 32'h0001_0000 + 32'($urandom_range(0, 3)),
               rn, rst, -1, -1, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
